// File: rtl/alu_multicycle_if.sv
// -----------------------------------------------------------------------------
// alu_multicycle_if
// Request/response bundle between the execute-stage control and the ALU.
//   start     : request, taken only when the ALU is not busy
//   op_mode   : 00 ADD, 01 SUB, 10 use func, 11 ADD
//   func      : operation select when op_mode = 10
//   in_1/in_2 : operands (in_1 = divisor, in_2 = dividend for DIVU/REMU)
//   busy      : iterative MUL/DIV in progress
//   done      : one-cycle completion pulse
//   result    : registered result, held until the next completion
//   zeroflag/ovf/divz : completion flags
// master = requester (control FSM / testbench), slave = ALU.
// -----------------------------------------------------------------------------
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op_mode;
    logic [2:0]       func;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zeroflag;
    logic             ovf;
    logic             divz;

    modport master (
        output start, op_mode, func, in_1, in_2,
        input  busy, done, result, zeroflag, ovf, divz
    );

    modport slave (
        input  start, op_mode, func, in_1, in_2,
        output busy, done, result, zeroflag, ovf, divz
    );
endinterface

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
// WIDTH-bit execute-stage ALU. ADD/SUB/NOT/AND/OR (and divide by zero) finish
// in one cycle; MUL and DIVU/REMU iterate one bit per cycle and finish
// WIDTH cycles after acceptance. All outputs are registered.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_multicycle_if.slave (start/op_mode/func/in_1/in_2 in,
//           busy/done/result/zeroflag/ovf/divz out)
// -----------------------------------------------------------------------------
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_multicycle_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] F_ADD  = 3'd0;
    localparam logic [2:0] F_SUB  = 3'd1;
    localparam logic [2:0] F_MUL  = 3'd2;
    localparam logic [2:0] F_NOT  = 3'd3;
    localparam logic [2:0] F_AND  = 3'd4;
    localparam logic [2:0] F_OR   = 3'd5;
    localparam logic [2:0] F_DIVU = 3'd6;
    localparam logic [2:0] F_REMU = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;       // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]   opnd;      // multiplicand (MUL) or divisor (DIV)
    logic               want_rem;

    logic               busy_r, done_r, zero_r, ovf_r, divz_r;
    logic [WIDTH-1:0]   result_r;

    // Signed overflow: operands of equal sign giving a sum of the other sign.
    function automatic logic add_ovf(input logic [WIDTH-1:0] a, b, s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Signed overflow of x - y: operands of different sign, result sign differs from x.
    function automatic logic sub_ovf(input logic [WIDTH-1:0] x, y, s);
        return (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    logic [2:0] fn_eff;
    always_comb begin
        case (bus.op_mode)
            2'b01:   fn_eff = F_SUB;
            2'b10:   fn_eff = bus.func;
            default: fn_eff = F_ADD;
        endcase
    end

    logic accept, mul_go, div_go;
    assign accept = (state == S_IDLE) && bus.start;
    assign mul_go = (fn_eff == F_MUL);
    // Divide by a nonzero divisor iterates; divide by zero completes at once.
    assign div_go = ((fn_eff == F_DIVU) || (fn_eff == F_REMU)) && (bus.in_1 != '0);

    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf, sc_divz;
    always_comb begin
        sc_res  = '0;
        sc_ovf  = 1'b0;
        sc_divz = 1'b0;
        case (fn_eff)
            F_ADD: begin
                sc_res = bus.in_1 + bus.in_2;
                sc_ovf = add_ovf(bus.in_1, bus.in_2, sc_res);
            end
            F_SUB: begin
                sc_res = bus.in_2 - bus.in_1;
                sc_ovf = sub_ovf(bus.in_2, bus.in_1, sc_res);
            end
            F_NOT:  sc_res = ~bus.in_1;
            F_AND:  sc_res = bus.in_1 & bus.in_2;
            F_OR:   sc_res = bus.in_1 | bus.in_2;
            F_DIVU: begin
                sc_res  = '1;
                sc_divz = 1'b1;
            end
            F_REMU: begin
                sc_res  = bus.in_2;
                sc_divz = 1'b1;
            end
            default: sc_res = '0;
        endcase
    end

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier bit (acc[0] = in_1 bit cnt) is set, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step: shift next dividend bit into the remainder, subtract the
    // divisor and keep the difference only if it did not go negative.
    logic [WIDTH:0]     div_top, div_diff;
    logic [2*WIDTH-1:0] div_nxt;
    logic [WIDTH-1:0]   div_res;
    assign div_top  = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_top - {1'b0, opnd};
    assign div_nxt  = div_diff[WIDTH] ? {div_top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign div_res  = want_rem ? div_nxt[2*WIDTH-1:WIDTH] : div_nxt[WIDTH-1:0];

    logic last;
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && mul_go)      state_nxt = S_MUL;
                else if (accept && div_go) state_nxt = S_DIV;
            end
            S_MUL, S_DIV: if (last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            want_rem <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
            divz_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (mul_go || div_go) begin
                            cnt      <= '0;
                            busy_r   <= 1'b1;
                            want_rem <= (fn_eff == F_REMU);
                            acc      <= mul_go ? {{WIDTH{1'b0}}, bus.in_1} : {{WIDTH{1'b0}}, bus.in_2};
                            opnd     <= mul_go ? bus.in_2 : bus.in_1;
                        end else begin
                            result_r <= sc_res;
                            zero_r   <= (sc_res == '0);
                            ovf_r    <= sc_ovf;
                            divz_r   <= sc_divz;
                            done_r   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_nxt;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        result_r <= mul_nxt[WIDTH-1:0];
                        zero_r   <= (mul_nxt[WIDTH-1:0] == '0);
                        ovf_r    <= |mul_nxt[2*WIDTH-1:WIDTH];
                        divz_r   <= 1'b0;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                end
                S_DIV: begin
                    acc <= div_nxt;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        result_r <= div_res;
                        zero_r   <= (div_res == '0);
                        ovf_r    <= 1'b0;
                        divz_r   <= 1'b0;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                end
                default: busy_r <= 1'b0;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.result   = result_r;
    assign bus.zeroflag = zero_r;
    assign bus.ovf      = ovf_r;
    assign bus.divz     = divz_r;
endmodule
